// File: rtl/commit_sched.sv
// rtl/commit_sched.sv - in-order ROB commit scheduler; optional same-cycle writeback bypass via COMMIT_BYPASS_EN
module commit_sched #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2 ** TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_rob_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_rob_tag,
  input  logic [31:0]      wb_val,
  input  logic             flush,
  output logic             commit_sig,
  output logic [4:0]       commit_reg,
  output logic [31:0]      commit_val,
  output logic [TAG_W-1:0] commit_rob_tag,
  output logic             clear,
  output logic [TAG_W:0]   count
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] done_q;
  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count_q;
  logic             issue_go;
  logic             wb_go;
  logic             bypass_hit;

  // Ready depends on occupancy only, so a full queue stays closed even while the head commits.
  assign issue_ready   = count_q < (TAG_W+1)'(DEPTH);
  assign issue_rob_tag = tail;
  assign count         = count_q;
  assign clear         = flush && rdy;

  assign issue_go = issue_valid && issue_ready && !flush && rdy;
  assign wb_go    = wb_valid && rdy && busy_q[wb_rob_tag] && !flush;

`ifdef COMMIT_BYPASS_EN
  assign bypass_hit = wb_valid && (wb_rob_tag == head) && busy_q[head] && !done_q[head];
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_sig     = rdy && busy_q[head] && (done_q[head] || bypass_hit);
  assign commit_reg     = rd_q[head];
  assign commit_val     = bypass_hit ? wb_val : val_q[head];
  assign commit_rob_tag = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
        busy_q  <= '0;
        done_q  <= '0;
      end else begin
        if (wb_go) begin
          done_q[wb_rob_tag] <= 1'b1;
          val_q[wb_rob_tag]  <= wb_val;
        end
        if (issue_go) begin
          busy_q[tail] <= 1'b1;
          done_q[tail] <= 1'b0;
          rd_q[tail]   <= issue_rd;
          tail         <= tail + TAG_W'(1);
        end
        // Head and tail only coincide when empty or full, so issue and commit never share an entry.
        if (commit_sig) begin
          busy_q[head] <= 1'b0;
          done_q[head] <= 1'b0;
          head         <= head + TAG_W'(1);
        end
        case ({issue_go, commit_sig})
          2'b10:   count_q <= count_q + (TAG_W+1)'(1);
          2'b01:   count_q <= count_q - (TAG_W+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_commit_sched.sv
// tb/tb_commit_sched.sv - randomized bench for commit_sched against an in-order queue model
module tb_commit_sched;
  localparam int TAG_W = 4;
  localparam int DEPTH = 16;
`ifdef COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, rdy, issue_valid, wb_valid, flush;
  logic [4:0]       issue_rd;
  logic [TAG_W-1:0] wb_rob_tag;
  logic [31:0]      wb_val;
  logic             issue_ready, commit_sig, clear;
  logic [TAG_W-1:0] issue_rob_tag, commit_rob_tag;
  logic [4:0]       commit_reg;
  logic [31:0]      commit_val;
  logic [TAG_W:0]   count;

  commit_sched #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_rob_tag(issue_rob_tag),
    .wb_valid(wb_valid), .wb_rob_tag(wb_rob_tag), .wb_val(wb_val),
    .flush(flush),
    .commit_sig(commit_sig), .commit_reg(commit_reg), .commit_val(commit_val),
    .commit_rob_tag(commit_rob_tag), .clear(clear), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [4:0] rd;
    bit         done;
    logic [31:0] val;
  } ent_t;

  ent_t mq[$];
  int   mh, mt;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rob_tag = '0; wb_val = '0;
  endtask

  task automatic wb(input int tag, input logic [31:0] v);
    idle();
    wb_valid = 1'b1; wb_rob_tag = TAG_W'(tag); wb_val = v;
  endtask

  // Called at negedge with inputs applied: check outputs, clock once, advance the model.
  task automatic step();
    bit          ec, acc;
    logic [31:0] ev;
    ent_t        e;
    #1;
    ec = 1'b0; ev = '0;
    if (rdy && mq.size() > 0) begin
      if (mq[0].done) begin
        ec = 1'b1; ev = mq[0].val;
      end else if (BYP && wb_valid && int'(wb_rob_tag) == mh) begin
        ec = 1'b1; ev = wb_val;
      end
    end
    check_eq("issue_ready", 64'(issue_ready), 64'(mq.size() < DEPTH));
    check_eq("issue_rob_tag", 64'(issue_rob_tag), 64'(mt));
    check_eq("count", 64'(count), 64'(mq.size()));
    check_eq("clear", 64'(clear), 64'(flush && rdy));
    check_eq("commit_sig", 64'(commit_sig), 64'(ec));
    check_eq("commit_rob_tag", 64'(commit_rob_tag), 64'(mh));
    if (ec) begin
      check_eq("commit_reg", 64'(commit_reg), 64'(mq[0].rd));
      check_eq("commit_val", 64'(commit_val), 64'(ev));
    end
    acc = issue_valid && (mq.size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      mq.delete(); mh = 0; mt = 0;
    end else if (rdy) begin
      if (flush) begin
        mq.delete(); mh = 0; mt = 0;
      end else begin
        if (wb_valid)
          foreach (mq[i])
            if (mq[i].tag == int'(wb_rob_tag)) begin
              mq[i].done = 1'b1; mq[i].val = wb_val;
            end
        if (ec) begin
          void'(mq.pop_front()); mh = (mh + 1) % DEPTH;
        end
        if (acc) begin
          e.tag = mt; e.rd = issue_rd; e.done = 1'b0; e.val = '0;
          mq.push_back(e); mt = (mt + 1) % DEPTH;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b1; flush = 1'b1; issue_valid = 1'b1; wb_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    mq.delete(); mh = 0; mt = 0;
    idle();
    #1;
    check_eq("rst_issue_ready", 64'(issue_ready), 64'd1);
    check_eq("rst_issue_tag", 64'(issue_rob_tag), 64'd0);
    check_eq("rst_commit_sig", 64'(commit_sig), 64'd0);
    check_eq("rst_commit_reg", 64'(commit_reg), 64'd0);
    check_eq("rst_commit_val", 64'(commit_val), 64'd0);
    check_eq("rst_commit_tag", 64'(commit_rob_tag), 64'd0);
    check_eq("rst_clear", 64'(clear), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    step();

    // three issues, out-of-order writeback
    for (int i = 0; i < 3; i++) begin
      idle(); issue_valid = 1'b1; issue_rd = 5'(5 + i);
      #1 check_eq("iss_tag", 64'(issue_rob_tag), 64'(i));
      step();
    end
    idle(); #1 check_eq("count3", 64'(count), 64'd3);
    wb(1, 32'hAA); #1 check_eq("wb1_nocommit", 64'(commit_sig), 64'd0);
    step();
    wb(0, 32'h11); #1;
    if (BYP) begin
      check_eq("c0_sig", 64'(commit_sig), 64'd1);
      check_eq("c0_val", 64'(commit_val), 64'h11);
    end else
      check_eq("c0_wait", 64'(commit_sig), 64'd0);
    step();
    if (!BYP) begin
      idle(); #1;
      check_eq("c0_sig", 64'(commit_sig), 64'd1);
      check_eq("c0_reg", 64'(commit_reg), 64'd5);
      check_eq("c0_val", 64'(commit_val), 64'h11);
      step();
    end
    idle(); #1;
    check_eq("c1_sig", 64'(commit_sig), 64'd1);
    check_eq("c1_reg", 64'(commit_reg), 64'd6);
    check_eq("c1_val", 64'(commit_val), 64'hAA);
    check_eq("c1_tag", 64'(commit_rob_tag), 64'd1);
    step();
    idle(); flush = 1'b1; step();

    // fill, overflow attempt, wrap
    for (int i = 0; i < DEPTH; i++) begin
      idle(); issue_valid = 1'b1; issue_rd = 5'(i); step();
    end
    idle(); #1;
    check_eq("full_ready", 64'(issue_ready), 64'd0);
    check_eq("full_count", 64'(count), 64'd16);
    issue_valid = 1'b1; step();
    idle(); #1 check_eq("full_17th", 64'(count), 64'd16);
    wb(0, 32'h1234); issue_valid = 1'b1;
    #1 check_eq("full_commit_ready", 64'(issue_ready), 64'd0);
    step();
    if (!BYP) begin
      idle(); issue_valid = 1'b1;
      #1 check_eq("full_commit_ready", 64'(issue_ready), 64'd0);
      step();
    end
    idle(); #1;
    check_eq("wrap_count", 64'(count), 64'd15);
    check_eq("wrap_ready", 64'(issue_ready), 64'd1);
    check_eq("wrap_tag", 64'(issue_rob_tag), 64'd0);

    // flush with a ready head
    wb(2, 32'h22); step();
    wb(1, 32'h21); step();
    idle(); flush = 1'b1; #1;
    check_eq("flush_clear", 64'(clear), 64'd1);
    check_eq("flush_commit", 64'(commit_sig), 64'd1);
    step();
    idle(); #1;
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_tail", 64'(issue_rob_tag), 64'd0);
    check_eq("flush_head", 64'(commit_rob_tag), 64'd0);

    // head tag 3 writeback timing
    for (int i = 0; i < 5; i++) begin
      idle(); issue_valid = 1'b1; issue_rd = 5'(10 + i); step();
    end
    for (int i = 0; i < 3; i++) begin
      wb(i, 32'(i + 1)); step();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); step();
    end
    idle(); #1;
    check_eq("h3_tag", 64'(commit_rob_tag), 64'd3);
    check_eq("h3_idle", 64'(commit_sig), 64'd0);
    wb(3, 32'h55); #1;
    if (BYP) begin
      check_eq("h3_byp_sig", 64'(commit_sig), 64'd1);
      check_eq("h3_byp_val", 64'(commit_val), 64'h55);
    end else
      check_eq("h3_nobyp_sig", 64'(commit_sig), 64'd0);
    step();
    if (!BYP) begin
      idle(); #1;
      check_eq("h3_late_sig", 64'(commit_sig), 64'd1);
      check_eq("h3_late_val", 64'(commit_val), 64'h55);
      step();
    end
    wb(4, 32'h44); step();
    idle(); step(); step();

    // rdy gating
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; step();
    idle(); issue_valid = 1'b1; issue_rd = 5'd8; step();
    wb(6, 32'h66); step();
    wb(5, 32'h65); step();
    idle(); rdy = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
    n = mq.size();
    #1 check_eq("rdy0_commit", 64'(commit_sig), 64'd0);
    step();
    #1 check_eq("rdy0_count", 64'(count), 64'(n));
    rdy = 1'b1;
    #1 check_eq("rdy1_commit", 64'(commit_sig), 64'd1);
    step();
    idle(); #1 check_eq("rdy1_count", 64'(count), 64'(n));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy         = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_rd    = 5'($urandom);
      wb_valid    = ($urandom_range(0, 9) < 6);
      wb_rob_tag  = ($urandom_range(0, 1) != 0) ? TAG_W'(mh) : TAG_W'($urandom);
      wb_val      = $urandom;
      flush       = ($urandom_range(0, 99) < 2);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
